// File: rtl/link_tx.sv
// link_tx: send/ready transmit source holding PE words in a DEPTH-entry FIFO.
// Define LINK_TX_STATS_EN to add the saturating tx_sent_cnt delivery counter.
module link_tx #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pe_wr,
    input  logic [DATA_W-1:0] pe_di,
    input  logic              pe_flush,
    output logic              pe_full,
    output logic [ADDR_W:0]   pe_count,
    output logic              pe_ovf,
`ifdef LINK_TX_STATS_EN
    output logic [15:0]       tx_sent_cnt,
`endif
    input  logic              tx_en,
    input  logic              tx_ri,
    output logic              tx_so,
    output logic [DATA_W-1:0] tx_do
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              wr_accept;
    logic              rd_fire;

    // Status is decoded from registered count only, so tx_so never sees tx_ri.
    assign tx_so     = (count != '0);
    assign pe_full   = (count == FULL_CNT);
    assign pe_count  = count;
    assign tx_do     = tx_so ? mem[rd_ptr] : '0;
    assign rd_fire   = tx_en & tx_so & tx_ri;
    assign wr_accept = pe_wr & ~pe_full;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pe_ovf <= 1'b0;
        end else if (pe_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pe_ovf <= 1'b0;
        end else begin
            if (rd_fire)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pe_wr & pe_full)
                pe_ovf <= 1'b1;
            case ({wr_accept, rd_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; tx_do is masked to zero while empty so stale entries never leak.
    always_ff @(posedge clk) begin
        if (wr_accept && !pe_flush)
            mem[wr_ptr] <= pe_di;
    end

`ifdef LINK_TX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tx_sent_cnt <= '0;
        else if (pe_flush)
            tx_sent_cnt <= '0;
        else if (rd_fire && tx_sent_cnt != 16'hFFFF)
            tx_sent_cnt <= tx_sent_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_link_tx.sv
// Self-checking bench for link_tx: directed plan steps plus random traffic
// against a queue-based model. Honours LINK_TX_STATS_EN when defined.
module tb_link_tx;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              pe_wr;
    logic [DATA_W-1:0] pe_di;
    logic              pe_flush;
    logic              pe_full;
    logic [ADDR_W:0]   pe_count;
    logic              pe_ovf;
    logic              tx_en;
    logic              tx_ri;
    logic              tx_so;
    logic [DATA_W-1:0] tx_do;
`ifdef LINK_TX_STATS_EN
    logic [15:0]       tx_sent_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic [63:0] q[$];
    bit          ovf_m;
    int          sent_m;

    always #5 clk = ~clk;

    link_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pe_wr      (pe_wr),
        .pe_di      (pe_di),
        .pe_flush   (pe_flush),
        .pe_full    (pe_full),
        .pe_count   (pe_count),
        .pe_ovf     (pe_ovf),
`ifdef LINK_TX_STATS_EN
        .tx_sent_cnt(tx_sent_cnt),
`endif
        .tx_en      (tx_en),
        .tx_ri      (tx_ri),
        .tx_so      (tx_so),
        .tx_do      (tx_do)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        ovf_m  = 1'b0;
        sent_m = 0;
    endtask

    // Applies one clock edge of FIFO rules to the queue using the driven inputs.
    task automatic model_edge();
        bit          full;
        bit          rd;
        logic [63:0] tmp;
        full = (q.size() == DEPTH);
        rd   = tx_en && (q.size() != 0) && tx_ri;
        if (pe_flush) begin
            model_clear();
        end else begin
            if (rd) begin
                tmp = q.pop_front();
                if (sent_m < 65535) sent_m++;
            end
            if (pe_wr && !full) q.push_back(pe_di);
            if (pe_wr && full) ovf_m = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        check({tag, ".pe_count"}, 64'(pe_count), 64'(q.size()));
        check({tag, ".tx_so"},    64'(tx_so),    64'(q.size() != 0));
        check({tag, ".pe_full"},  64'(pe_full),  64'(q.size() == DEPTH));
        check({tag, ".pe_ovf"},   64'(pe_ovf),   64'(ovf_m));
        check({tag, ".tx_do"},    tx_do,         head);
`ifdef LINK_TX_STATS_EN
        check({tag, ".sent_cnt"}, 64'(tx_sent_cnt), 64'(sent_m));
`endif
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int peak;

        reset    = 1'b0;
        pe_wr    = 1'b0;
        pe_di    = '0;
        pe_flush = 1'b0;
        tx_en    = 1'b0;
        tx_ri    = 1'b0;
        model_clear();
        #3;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Streaming A, B, C with the link always ready.
        tx_en = 1'b1;
        tx_ri = 1'b1;
        pe_wr = 1'b1;
        pe_di = 64'hA;
        cycle("stream0");
        check("stream_first", tx_do, 64'hA);
        peak = int'(pe_count);
        pe_di = 64'hB;
        cycle("stream1");
        check("stream_second", tx_do, 64'hB);
        if (int'(pe_count) > peak) peak = int'(pe_count);
        pe_di = 64'hC;
        cycle("stream2");
        check("stream_third", tx_do, 64'hC);
        if (int'(pe_count) > peak) peak = int'(pe_count);
        pe_wr = 1'b0;
        cycle("stream_end");
        check("stream_peak", 64'(peak), 64'd1);

        // Backpressure holds the head word.
        tx_ri = 1'b0;
        pe_wr = 1'b1;
        pe_di = 64'h11;
        cycle("bp_w0");
        pe_di = 64'h22;
        cycle("bp_w1");
        pe_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold");
            check("bp_head", tx_do, 64'h11);
        end
        tx_ri = 1'b1;
        cycle("bp_rel0");
        check("bp_second", tx_do, 64'h22);
        cycle("bp_rel1");
        cycle("bp_rel2");

        // Overflow: fifth write is dropped and sets the sticky flag.
        tx_ri = 1'b0;
        pe_wr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pe_di = 64'(i);
            cycle("ovf_wr");
            if (i == 4) check("ovf_full_at4", 64'(pe_full), 64'd1);
        end
        check("ovf_flag", 64'(pe_ovf), 64'd1);
        pe_wr = 1'b0;
        tx_ri = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", tx_do, 64'(i));
            cycle("ovf_drain");
        end
        check("ovf_empty", 64'(tx_so), 64'd0);

        // Simultaneous read and write at count=2, wrapping the pointers.
        tx_ri = 1'b0;
        pe_wr = 1'b1;
        pe_di = 64'h100;
        cycle("sim_pre0");
        pe_di = 64'h101;
        cycle("sim_pre1");
        tx_ri = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pe_di = 64'h200 + 64'(i);
            cycle("sim_rw");
            check("sim_count", 64'(pe_count), 64'd2);
        end
        pe_wr = 1'b0;
        cycle("sim_drain0");
        cycle("sim_drain1");

        // Transmit gating, then flush with a concurrent write.
        tx_en = 1'b0;
        tx_ri = 1'b1;
        pe_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_di = 64'h300 + 64'(i);
            cycle("gate_wr");
        end
        pe_wr = 1'b0;
        cycle("gate_idle0");
        cycle("gate_idle1");
        check("gate_count", 64'(pe_count), 64'd3);
        pe_wr = 1'b1;
        pe_di = 64'h3F0;
        cycle("gate_fill");
        cycle("gate_ovf");
        pe_flush = 1'b1;
        pe_di    = 64'h3FF;
        cycle("flush");
        check("flush_count", 64'(pe_count), 64'd0);
        check("flush_ovf", 64'(pe_ovf), 64'd0);
        check("flush_do", tx_do, 64'd0);
        pe_flush = 1'b0;
        pe_wr    = 1'b0;
        tx_en    = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tx_en    = ($urandom_range(0, 3) != 0);
            tx_ri    = $urandom_range(0, 1) == 1;
            pe_wr    = $urandom_range(0, 1) == 1;
            pe_flush = ($urandom_range(0, 31) == 0);
            pe_di    = {$urandom, $urandom};
            cycle("rand");
        end

        // Asynchronous reset between edges with three words queued.
        tx_en    = 1'b1;
        tx_ri    = 1'b0;
        pe_wr    = 1'b0;
        pe_flush = 1'b1;
        cycle("ar_flush");
        pe_flush = 1'b0;
        pe_wr    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_di = 64'h500 + 64'(i);
            cycle("ar_fill");
        end
        pe_wr = 1'b0;
        check("ar_pre_count", 64'(pe_count), 64'd3);
        #4;
        reset = 1'b0;
        model_clear();
        #1;
        check("ar_count", 64'(pe_count), 64'd0);
        check("ar_so", 64'(tx_so), 64'd0);
        check_outputs("ar");
        @(negedge clk);
        reset = 1'b1;
        cycle("ar_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
